// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
// Shared RV32I decode definitions used by the main decoder and by imm_encode.
//   - IMM_* : immediate format select codes carried on instr_type
//   - word_t: 32-bit machine word
//   - sign_extend(): replicate bit 'msb' of a value into all higher bits
// ----------------------------------------------------------------------------
package rv_pkg;

    typedef logic [31:0] word_t;

    // Immediate format select; codes 3'b110 and 3'b111 are reserved.
    localparam logic [2:0] IMM_R = 3'b000;
    localparam logic [2:0] IMM_I = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_J = 3'b101;

    // Copy bit 'msb' of 'value' into every bit above it. Bits at and below
    // 'msb' pass through untouched, so callers may hand in a value whose
    // upper bits are zero-filled.
    function automatic word_t sign_extend(input word_t value, input logic [4:0] msb);
        word_t result;
        result = value;
        for (int i = 0; i < 32; i++) begin
            if (i > int'(msb)) begin
                result[i] = value[msb];
            end else begin
                result[i] = value[i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/imm_encode_if.sv
// ----------------------------------------------------------------------------
// imm_encode_if
// Decode-stage bundle between the main decoder and the immediate generator.
//   instr        [24:0] instruction bits 31..7 (opcode bits not carried)
//   instr_type   [2:0]  immediate format select (rv_pkg::IMM_*)
//   imm          [31:0] combinational immediate
//   imm_q        [31:0] immediate registered one clock later
//   type_illegal        instr_type is a reserved code
// Modports: master = decoder side, slave = imm_encode.
// ----------------------------------------------------------------------------
interface imm_encode_if;
    import rv_pkg::*;

    logic [24:0] instr;
    logic [2:0]  instr_type;
    word_t       imm;
    word_t       imm_q;
    logic        type_illegal;

    modport master (
        output instr,
        output instr_type,
        input  imm,
        input  imm_q,
        input  type_illegal
    );

    modport slave (
        input  instr,
        input  instr_type,
        output imm,
        output imm_q,
        output type_illegal
    );

endinterface

// File: rtl/imm_encode.sv
// ----------------------------------------------------------------------------
// imm_encode
// RV32I immediate generator for the decode stage. Produces the sign/zero
// extended immediate for formats R/I/S/B/U/J combinationally, flags reserved
// format codes, and provides a registered copy for the pipelined datapath.
// Ports:
//   clk    in  core clock (only the registered copy uses it)
//   rst_n  in  asynchronous active-low reset; clears imm_q only
//   bus    imm_encode_if.slave (instr, instr_type -> imm, imm_q, type_illegal)
// ----------------------------------------------------------------------------
module imm_encode
    import rv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    imm_encode_if.slave  bus
);

    word_t w_ir;          // instruction re-aligned so w_ir[n] is instr bit n
    word_t w_imm;
    logic  w_type_illegal;
    word_t r_imm_q;

    // The opcode field never reaches this block; pad it with zeros so the
    // bit indices below read exactly like the ISA manual.
    assign w_ir = {bus.instr, 7'b000_0000};

    // Immediate selection by format; every path assigns every output.
    always_comb begin
        w_imm          = 32'h0000_0000;
        w_type_illegal = 1'b0;
        case (bus.instr_type)
            IMM_R: begin
                w_imm          = 32'h0000_0000;
                w_type_illegal = 1'b0;
            end
            IMM_I: begin
                w_imm = sign_extend({20'h0_0000, w_ir[31:20]}, 5'd11);
            end
            IMM_S: begin
                w_imm = sign_extend({20'h0_0000, w_ir[31:25], w_ir[11:7]}, 5'd11);
            end
            IMM_B: begin
                // Bit 11 of the offset lives in instr[7]; bit 0 is implied.
                w_imm = sign_extend({19'h0_0000, w_ir[31], w_ir[7], w_ir[30:25],
                                     w_ir[11:8], 1'b0}, 5'd12);
            end
            IMM_U: begin
                w_imm = {w_ir[31:12], 12'h000};
            end
            IMM_J: begin
                // Scrambled jump offset: [20|10:1|11|19:12], bit 0 implied.
                w_imm = sign_extend({11'h000, w_ir[31], w_ir[19:12], w_ir[20],
                                     w_ir[30:21], 1'b0}, 5'd20);
            end
            3'b110, 3'b111: begin
                w_imm          = 32'h0000_0000;
                w_type_illegal = 1'b1;
            end
            default: begin
                // Only reachable with unknown select bits; treat as reserved.
                w_imm          = 32'h0000_0000;
                w_type_illegal = 1'b1;
            end
        endcase
    end

    // Pipeline copy of the immediate; reset clears it without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imm_q <= 32'h0000_0000;
        end else begin
            r_imm_q <= w_imm;
        end
    end

    assign bus.imm          = w_imm;
    assign bus.type_illegal = w_type_illegal;
    assign bus.imm_q        = r_imm_q;

endmodule

// File: tb/tb_imm_encode.sv
// ----------------------------------------------------------------------------
// tb_imm_encode
// Directed, table-driven bench for imm_encode with hand-computed immediates,
// plus hand-written sequences for the asynchronous reset of imm_q.
// ----------------------------------------------------------------------------
module tb_imm_encode;
    import rv_pkg::*;

    logic clk;
    logic rst_n;

    imm_encode_if bus ();

    imm_encode dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] word;
        logic [2:0]  typ;
        logic [31:0] exp_imm;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [12];
    int   errors;
    int   checks;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] word, input logic [2:0] typ);
        logic [31:0] w;
        w = word;
        bus.instr      = w[31:7];
        bus.instr_type = typ;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        vecs[0]  = '{"addi_neg1",   32'hFFF00093, IMM_I, 32'hFFFF_FFFF, 1'b0};
        vecs[1]  = '{"addi_7ff",    32'h7FF00093, IMM_I, 32'h0000_07FF, 1'b0};
        vecs[2]  = '{"sw_neg4",     32'hFE112E23, IMM_S, 32'hFFFF_FFFC, 1'b0};
        vecs[3]  = '{"b_min",       32'h80000063, IMM_B, 32'hFFFF_F000, 1'b0};
        vecs[4]  = '{"b_bit11",     32'h000000E3, IMM_B, 32'h0000_0800, 1'b0};
        vecs[5]  = '{"b_pos_max",   32'h7FFFFFE3, IMM_B, 32'h0000_0FFE, 1'b0};
        vecs[6]  = '{"lui_12345",   32'h123450B7, IMM_U, 32'h1234_5000, 1'b0};
        vecs[7]  = '{"lui_msb",     32'h80000037, IMM_U, 32'h8000_0000, 1'b0};
        vecs[8]  = '{"j_min",       32'h8000006F, IMM_J, 32'hFFF0_0000, 1'b0};
        vecs[9]  = '{"j_pos_max",   32'h7FFFF06F, IMM_J, 32'h000F_FFFE, 1'b0};
        vecs[10] = '{"j_as_r",      32'h8000006F, IMM_R, 32'h0000_0000, 1'b0};
        vecs[11] = '{"j_as_111",    32'h8000006F, 3'b111, 32'h0000_0000, 1'b1};

        // Reset held from time zero: imm_q clear before any clock edge.
        rst_n = 1'b0;
        drive(32'h123450B7, IMM_U);
        #2;
        check32("reset_imm_q_no_clk", bus.imm_q, 32'h0000_0000);
        check32("reset_imm_comb", bus.imm, 32'h1234_5000);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: combinational result mid-cycle, registered copy after the edge.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].word, vecs[i].typ);
            #1;
            check32({vecs[i].name, "_imm"}, bus.imm, vecs[i].exp_imm);
            check1({vecs[i].name, "_ill"}, bus.type_illegal, vecs[i].exp_ill);
            @(posedge clk);
            #1;
            check32({vecs[i].name, "_imm_q"}, bus.imm_q, vecs[i].exp_imm);
        end

        // Reserved code 110 as well.
        @(negedge clk);
        drive(32'h8000006F, 3'b110);
        #1;
        check32("j_as_110_imm", bus.imm, 32'h0000_0000);
        check1("j_as_110_ill", bus.type_illegal, 1'b1);

        // One-cycle latency: imm_q holds old value until the edge.
        @(negedge clk);
        drive(32'h123450B7, IMM_U);
        @(posedge clk);
        #1;
        check32("lat_load", bus.imm_q, 32'h1234_5000);
        @(negedge clk);
        drive(32'hFFF00093, IMM_I);
        #1;
        check32("lat_hold_before_edge", bus.imm_q, 32'h1234_5000);
        @(posedge clk);
        #1;
        check32("lat_after_edge", bus.imm_q, 32'hFFFF_FFFF);

        // Mid-stream reset: imm_q clears immediately, comb path keeps tracking.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check32("midrst_imm_q", bus.imm_q, 32'h0000_0000);
        check32("midrst_imm", bus.imm, 32'hFFFF_FFFF);
        drive(32'h8000006F, IMM_J);
        #1;
        check32("midrst_imm_track", bus.imm, 32'hFFF0_0000);
        @(posedge clk);
        #1;
        check32("midrst_imm_q_held", bus.imm_q, 32'h0000_0000);

        // Release and load the lui word on the first rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h123450B7, IMM_U);
        #1;
        check32("release_before_edge", bus.imm_q, 32'h0000_0000);
        @(posedge clk);
        #1;
        check32("release_first_edge", bus.imm_q, 32'h1234_5000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
